// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_pkg : shared constants and helpers for the irq_ctrl block        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package irq_pkg;

   localparam logic [2:0] IRQ_OFS_PENDING = 3'd0;
   localparam logic [2:0] IRQ_OFS_MASK    = 3'd1;
   localparam logic [2:0] IRQ_OFS_EDGE    = 3'd2;
   localparam logic [2:0] IRQ_OFS_VECTOR  = 3'd3;
   localparam logic [2:0] IRQ_OFS_EOI     = 3'd4;
   localparam logic [2:0] IRQ_OFS_SWSET   = 3'd5;
   localparam logic [2:0] IRQ_OFS_RAW     = 3'd6;

   localparam logic [1:0] IRQ_IDLE    = 2'd0;
   localparam logic [1:0] IRQ_REQ     = 2'd1;
   localparam logic [1:0] IRQ_SERVICE = 2'd2;

   localparam int IRQ_VEC_VALID_BIT = 7;

   // Lowest set index wins; returns 0 for an all-zero vector.
   function automatic logic [2:0] irq_lowest(input logic [7:0] v);
      irq_lowest = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) irq_lowest = 3'(i);
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_sync_edge : 2-flop synchronizer with rising-edge detect          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise
);
   logic s1_q, s2_q, dly_q;
   logic s1_d, s2_d, dly_d;

   always_comb begin
      s1_d  = async_in;
      s2_d  = s1_q;
      dly_d = s2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         dly_q <= 1'b0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         dly_q <= dly_d;
      end
   end

   assign level = s2_q;
   assign rise  = s2_q & ~dly_q;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_ctrl : 8-source memory-mapped interrupt controller               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irq_ctrl
   import irq_pkg::*;
#(
   parameter logic [15:0] BASE = 16'hFF00,
   parameter int          NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [15:0]     address,
   input  logic            read,
   input  logic [7:0]      wdata,
   output logic [7:0]      rdata,
   output logic            sel,
   input  logic [NSRC-1:0] irq_src,
   output logic            intr
);
   localparam logic [7:0] SRC_MASK = 8'((1 << NSRC) - 1);

   logic [7:0] level, rise;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_src
         if (gi < NSRC) begin : g_used
            irq_sync_edge u_sync (
               .clk      (clk),
               .rst      (rst),
               .async_in (irq_src[gi]),
               .level    (level[gi]),
               .rise     (rise[gi])
            );
         end else begin : g_unused
            assign level[gi] = 1'b0;
            assign rise[gi]  = 1'b0;
         end
      end
   endgenerate

   logic [7:0] pending_q, pending_d, mask_q, mask_d, edge_q, edge_d;
   logic [1:0] state_q, state_d;
   logic [2:0] cur_id_q, cur_id_d;
   logic       intr_q, intr_d, vec_prev_q, vec_prev_d;

   logic [2:0] ofs, win_id;
   logic [7:0] active, set_v, clr_v;
   logic       wr_en, vec_rd, vec_first, eoi_wr, take;

   assign sel       = (address[15:3] == BASE[15:3]);
   assign ofs       = address[2:0];
   assign wr_en     = sel & ~read;
   assign vec_rd    = sel & read & (ofs == IRQ_OFS_VECTOR);
   assign vec_first = vec_rd & ~vec_prev_q;
   assign eoi_wr    = wr_en & (ofs == IRQ_OFS_EOI);
   assign active    = pending_q & mask_q;
   assign win_id    = irq_lowest(active);

   always_comb begin
      mask_d   = mask_q;
      edge_d   = edge_q;
      state_d  = state_q;
      cur_id_d = cur_id_q;
      take     = 1'b0;
      if (wr_en && ofs == IRQ_OFS_MASK) mask_d = wdata & SRC_MASK;
      if (wr_en && ofs == IRQ_OFS_EDGE) edge_d = wdata & SRC_MASK;

      case (state_q)
         IRQ_IDLE:    if (|active) state_d = IRQ_REQ;
         IRQ_REQ: begin
            if (~|active) begin
               state_d = IRQ_IDLE;
            end else if (vec_first) begin
               take     = 1'b1;
               cur_id_d = win_id;
               state_d  = IRQ_SERVICE;
            end
         end
         IRQ_SERVICE: if (eoi_wr) state_d = IRQ_IDLE;
         default:     state_d = IRQ_IDLE;
      endcase

      // Edge sources latch; a set in the same cycle as a clear wins.
      set_v = rise | ((wr_en && ofs == IRQ_OFS_SWSET) ? wdata : 8'h00);
      clr_v = ((wr_en && ofs == IRQ_OFS_PENDING) ? wdata : 8'h00)
            | (take ? (8'h01 << win_id) : 8'h00);
      pending_d = SRC_MASK & ((edge_q & (set_v | (pending_q & ~clr_v)))
                            | (~edge_q & level));

      intr_d     = (state_d == IRQ_REQ);
      vec_prev_d = vec_rd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q  <= 8'h00;
         mask_q     <= 8'h00;
         edge_q     <= 8'h00;
         state_q    <= IRQ_IDLE;
         cur_id_q   <= 3'd0;
         intr_q     <= 1'b0;
         vec_prev_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         state_q    <= state_d;
         cur_id_q   <= cur_id_d;
         intr_q     <= intr_d;
         vec_prev_q <= vec_prev_d;
      end
   end

   assign intr = intr_q;

   always_comb begin
      rdata = 8'h00;
      if (sel) begin
         case (ofs)
            IRQ_OFS_PENDING: rdata = pending_q;
            IRQ_OFS_MASK:    rdata = mask_q;
            IRQ_OFS_EDGE:    rdata = edge_q;
            IRQ_OFS_VECTOR: begin
               if (state_q == IRQ_REQ)
                  rdata = {1'b1, 4'b0000, win_id};
               else if (state_q == IRQ_SERVICE)
                  rdata = {1'b1, 4'b0000, cur_id_q};
            end
            IRQ_OFS_RAW:     rdata = level;
            default:         rdata = 8'h00;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irq_ctrl : directed vector bench for irq_ctrl                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_irq_ctrl;
   localparam logic [15:0] BASE = 16'hFF00;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] address;
   logic        read;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        sel;
   logic [7:0]  irq_src;
   logic        intr;

   int checks = 0;
   int errors = 0;

   irq_ctrl #(.BASE(BASE), .NSRC(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .address (address),
      .read    (read),
      .wdata   (wdata),
      .rdata   (rdata),
      .sel     (sel),
      .irq_src (irq_src),
      .intr    (intr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       wr;
      logic [2:0] ofs;
      logic [7:0] wdata;
      logic [7:0] src;
      logic [7:0] exp_rdata;
      logic       exp_intr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic w, input logic [2:0] o,
                              input logic [7:0] d, input logic [7:0] s,
                              input logic [7:0] er, input logic ei);
      vec_t x;
      x.rst = r; x.wr = w; x.ofs = o; x.wdata = d; x.src = s;
      x.exp_rdata = er; x.exp_intr = ei;
      return x;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [2:0] ofs, input logic [7:0] d);
      address = {BASE[15:3], ofs};
      read    = 1'b0;
      wdata   = d;
      step();
      read    = 1'b1;
      address = 16'h0000;
   endtask

   task automatic rd_chk(input logic [2:0] ofs, input logic [7:0] exp, input string name);
      address = {BASE[15:3], ofs};
      read    = 1'b1;
      #1;
      chk(name, rdata, exp);
      address = 16'h0000;
   endtask

   task automatic vec_rd(input logic [7:0] exp, input string name);
      address = {BASE[15:3], 3'd3};
      read    = 1'b1;
      #1;
      chk(name, rdata, exp);
      step();
      address = 16'h0000;
   endtask

   task automatic pulse(input logic [7:0] m);
      irq_src = m;
      step();
      irq_src = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; address = 16'h0000; read = 1'b1; wdata = 8'h00; irq_src = 8'h00;
      step();

      // Sources high through reset, all level, masked.
      tbl.push_back(v(1, 0, 7, 8'h00, 8'hFF, 8'h00, 0));
      tbl.push_back(v(1, 0, 7, 8'h00, 8'hFF, 8'h00, 0));
      tbl.push_back(v(0, 0, 6, 8'h00, 8'hFF, 8'h00, 0));
      tbl.push_back(v(0, 0, 6, 8'h00, 8'hFF, 8'h00, 0));
      tbl.push_back(v(0, 0, 6, 8'h00, 8'hFF, 8'hFF, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'hFF, 8'hFF, 0));
      tbl.push_back(v(0, 0, 1, 8'h00, 8'hFF, 8'h00, 0));
      tbl.push_back(v(0, 0, 3, 8'h00, 8'hFF, 8'h00, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'hFF, 8'hFF, 0));
      // Edge sources 2 and 5 pulsed together.
      tbl.push_back(v(1, 0, 7, 8'h00, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 1, 2, 8'hFF, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 1, 1, 8'h24, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 0, 7, 8'h00, 8'h24, 8'h00, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h24, 1));
      tbl.push_back(v(0, 0, 3, 8'h00, 8'h00, 8'h82, 0));
      tbl.push_back(v(0, 0, 3, 8'h00, 8'h00, 8'h82, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h20, 0));
      tbl.push_back(v(0, 1, 4, 8'h00, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 0, 7, 8'h00, 8'h00, 8'h00, 1));
      tbl.push_back(v(0, 0, 3, 8'h00, 8'h00, 8'h85, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 1, 4, 8'h00, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 0, 7, 8'h00, 8'h00, 8'h00, 0));
      // Level source 0: W1C ignored, drop before VECTOR returns to IDLE.
      tbl.push_back(v(1, 0, 7, 8'h00, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 1, 1, 8'h01, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 0, 7, 8'h00, 8'h01, 8'h00, 0));
      tbl.push_back(v(0, 0, 7, 8'h00, 8'h01, 8'h00, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h01, 8'h00, 0));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h01, 8'h01, 1));
      tbl.push_back(v(0, 1, 0, 8'h01, 8'h01, 8'h01, 1));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h01, 8'h01, 1));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h01, 1));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h01, 1));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h01, 1));
      tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
      tbl.push_back(v(0, 0, 3, 8'h00, 8'h00, 8'h00, 0));

      foreach (tbl[i]) begin
         rst     = tbl[i].rst;
         address = {BASE[15:3], tbl[i].ofs};
         read    = ~tbl[i].wr;
         wdata   = tbl[i].wdata;
         irq_src = tbl[i].src;
         #1;
         chk($sformatf("row%0d_rdata", i), rdata, tbl[i].exp_rdata);
         step();
         chk($sformatf("row%0d_intr", i), {7'b0, intr}, {7'b0, tbl[i].exp_intr});
         read = 1'b1;
      end
      rst = 1'b0;

      // Window decode.
      address = 16'h1234;
      #1;
      chk("unsel_rdata", rdata, 8'h00);
      chk("unsel_sel", {7'b0, sel}, 8'h00);
      address = BASE + 16'h0007;
      #1;
      chk("sel_hit", {7'b0, sel}, 8'h01);

      // Re-pend of the in-service source, then SWSET.
      do_reset();
      wr_reg(3'd2, 8'hFF);
      wr_reg(3'd1, 8'h48);
      pulse(8'h08);
      step();
      step();
      chk("s5_intr_e3", {7'b0, intr}, 8'h00);
      step();
      chk("s5_intr_e4", {7'b0, intr}, 8'h01);
      vec_rd(8'h83, "s5_vec1");
      chk("s5_intr_svc", {7'b0, intr}, 8'h00);
      pulse(8'h08);
      step();
      step();
      rd_chk(3'd0, 8'h08, "s5_repend");
      chk("s5_intr_hold", {7'b0, intr}, 8'h00);
      step();
      chk("s5_intr_hold2", {7'b0, intr}, 8'h00);
      wr_reg(3'd4, 8'h5A);
      chk("s5_intr_eoi", {7'b0, intr}, 8'h00);
      step();
      chk("s5_intr_after_eoi", {7'b0, intr}, 8'h01);
      vec_rd(8'h83, "s5_vec2");
      wr_reg(3'd4, 8'h00);
      wr_reg(3'd5, 8'h40);
      chk("s5_swset_e1", {7'b0, intr}, 8'h00);
      step();
      chk("s5_swset_e2", {7'b0, intr}, 8'h01);
      vec_rd(8'h86, "s5_vec_sw");

      // W1C colliding with a new rise, then reset while in SERVICE.
      do_reset();
      wr_reg(3'd2, 8'hFF);
      pulse(8'h02);
      step();
      wr_reg(3'd0, 8'h02);
      rd_chk(3'd0, 8'h02, "s6_set_beats_clr");
      wr_reg(3'd0, 8'h02);
      rd_chk(3'd0, 8'h00, "s6_w1c");
      wr_reg(3'd1, 8'h02);
      wr_reg(3'd5, 8'h02);
      step();
      chk("s6_intr_req", {7'b0, intr}, 8'h01);
      vec_rd(8'h81, "s6_vec");
      wr_reg(3'd1, 8'hFF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("s6_rst_intr", {7'b0, intr}, 8'h00);
      rd_chk(3'd1, 8'h00, "s6_rst_mask");
      rd_chk(3'd0, 8'h00, "s6_rst_pending");
      vec_rd(8'h00, "s6_rst_vec_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual running required finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller that arbitrates eight external interrupt sources onto the single level-sensitive `intr` input of `cpu`. It sits on the CPU byte bus (`address`, `read`, `dout`, `din`) as a peripheral and selects the highest-priority pending, enabled source. It hands the selected ID to the supervisor handler through a VECTOR read and holds further requests off until the handler writes EOI.

## Interface
- `BASE`, default 16'hFF00: register window base; must be 8-byte aligned (decode is `address[15:3] == BASE[15:3]`).
- `NSRC`, default 8: number of sources, 1..8; unused bits read 0 and never pend.

- `clk`  in  1  clock; all state updates on the rising edge (CPU drives the bus on the falling edge).
- `rst`  in  1  reset: synchronous, active-high.
- `address`  in  16  CPU address.
- `read`  in  1  CPU strobe; 1 = read/idle, 0 = write (low for exactly one cycle per written byte).
- `wdata`  in  8  CPU write data (`dout`).
- `rdata`  out  8  read data, combinational from `address`; 0 when not selected.
- `sel`  out  1  `address` hits the window; steers the system `din` mux.
- `irq_src`  in  NSRC  asynchronous interrupt inputs, active-high.
- `intr`  out  1  registered interrupt request to the CPU.

## Operation
- Registers, offset = `address[2:0]`:
  - 0 PENDING: R; W1C, edge sources only.
  - 1 MASK: RW; 1 = enabled.
  - 2 EDGE: RW; 1 = rising-edge, 0 = level.
  - 3 VECTOR: R, with side effect.
  - 4 EOI: W, any value.
  - 5 SWSET: W; 1 sets the pending bit of edge sources.
  - 6 RAW: R; synchronized inputs.
  - 7: reads 0.
- Writes to read-only offsets and reads of write-only offsets have no effect and return 0.
- Write commit: rising edge with `sel & ~read`.
- Pending update:
  - Level source: pending bit = synchronized input.
  - Edge source: bit sets on a 0->1 of the synchronized input or on SWSET; clears on W1C.
  - Set beats clear in the same cycle.
- Priority: lowest index wins among `pending & MASK`.
- State machine, one of three states:
  - IDLE: `intr` = 0. Go to REQ when `|(pending & MASK)`.
  - REQ: `intr` = 1. Go back to IDLE if `pending & MASK` becomes 0. On a VECTOR read, latch the winning ID into `cur_id`, clear that pending bit if it is an edge source, and go to SERVICE.
  - SERVICE: `intr` = 0 regardless of pending. Go to IDLE on an EOI write.
- VECTOR read data:
  - REQ: `{1'b1, 4'b0, id}`, with `id` computed live.
  - SERVICE: `{1'b1, 4'b0, cur_id}`.
  - IDLE: 8'h00 (spurious; no state change).
- VECTOR side effect fires only on the first cycle of a read-select of offset 3. A registered "previous cycle selected offset 3" flag suppresses repeats while the address is held.
- EOI in IDLE or REQ: ignored.

## Timing
- Synchronizer: 2 flops per source. Edge detect compares sync stage 2 against its delayed copy.
- Latency:
  - `irq_src` rising (sampled at edge 1) -> pending at edge 3 -> `intr` = 1 after edge 4.
  - VECTOR read edge -> `intr` = 0 after the same edge.
  - EOI edge -> IDLE. If work remains pending, `intr` = 1 one edge later.
- Reset values:
  - `intr` 0, state IDLE, MASK 0, EDGE 0, PENDING 0, `cur_id` 0.
  - Sync and delay flops 0, so a source held high through reset produces no edge.
  - `rdata`/`sel` follow `address`.
- Reset mid-SERVICE: returns to IDLE with everything cleared; no EOI needed.
- An edge on the in-service source during SERVICE re-pends that source; it is taken after EOI.
- MASK or EDGE change takes effect on the next edge's REQ evaluation.

## Structure
- Shared package `irq_pkg`:
  - Register offset constants `IRQ_OFS_PENDING` .. `IRQ_OFS_RAW`.
  - State enum `IRQ_IDLE`/`IRQ_REQ`/`IRQ_SERVICE`.
  - VECTOR valid bit position.
- Sub-module `irq_sync_edge`, one instance per source: 2-flop synchronizer plus delay flop; outputs `level` and `rise`.
- Top: register file, priority encoder, FSM, read mux.

## Test plan
- Reset with `irq_src` = 8'hFF, MASK 0: `intr` stays 0; RAW reads 8'hFF after 2 edges; PENDING reads 8'hFF (all level).
- EDGE = 8'hFF, MASK = 8'h24, pulse sources 2 and 5 on the same edge: `intr` = 1 after edge 4; VECTOR reads 8'h82; PENDING then reads 8'h20; `intr` = 0 until EOI; after EOI, `intr` = 1 and VECTOR reads 8'h85.
- VECTOR read in IDLE: returns 8'h00; state, PENDING and `intr` unchanged.
- Level source 0, MASK = 8'h01: raise -> `intr` = 1; drop before the VECTOR read -> `intr` = 0 (IDLE); W1C to bit 0 has no effect.
- Edge source 3 in SERVICE with `cur_id` = 3: pulse source 3 again -> PENDING bit 3 = 1, `intr` stays 0; after EOI, `intr` = 1. Also: SWSET 8'h40 with EDGE bit 6 and MASK bit 6 set -> `intr` = 1 two edges later.
- W1C of bit 1 on the same edge as a new rise on source 1: PENDING bit 1 stays 1. Assert `rst` in SERVICE: next cycle `intr` = 0, MASK reads 8'h00.
